// File: rtl/psum_drain_pkg.sv
// -----------------------------------------------------------------------------
// npu_drain_pkg
// Shared definitions for the psum_drain output stage:
//   - drain_state_e : serializer states (IDLE, SEND)
//   - COL_DEF / BW_PSUM_DEF / DEPTH_DEF : default geometry
//   - col_slice()   : extracts one column word from a packed psum vector
// Optional feature macro used by this slice: PSUM_DRAIN_RELU_EN.
// -----------------------------------------------------------------------------
package npu_drain_pkg;

    localparam int COL_DEF     = 8;
    localparam int BW_PSUM_DEF = 20;
    localparam int DEPTH_DEF   = 4;

    // Upper bounds for the slice helper; vectors are zero-extended to this.
    localparam int MAX_VEC_W = 1024;
    localparam int MAX_BW_W  = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_e;

    // Column k of a packed vector whose words are bw bits wide; column 0 sits
    // in the least significant bits. Callers truncate the result to bw bits.
    function automatic logic [MAX_BW_W-1:0] col_slice(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   k,
        input int                   bw
    );
        logic [MAX_VEC_W-1:0] mask_s;
        logic [MAX_VEC_W-1:0] shifted_s;
        mask_s    = ~({MAX_VEC_W{1'b1}} << bw);
        shifted_s = (vec >> (k * bw)) & mask_s;
        return MAX_BW_W'(shifted_s);
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// -----------------------------------------------------------------------------
// psum_drain_if
// Bundles the two streams of the drain stage.
//   Capture side : psum_in, psum_valid (to drain), psum_ready (from drain)
//   Output side  : dout, dout_valid, dout_idx, dout_last (from drain),
//                  dout_ready (to drain)
// Modports: slave = the drain block, master = the environment around it.
// -----------------------------------------------------------------------------
interface psum_drain_if #(
    parameter int COL     = npu_drain_pkg::COL_DEF,
    parameter int BW_PSUM = npu_drain_pkg::BW_PSUM_DEF
) ();

    logic [BW_PSUM*COL-1:0]   psum_in;
    logic                     psum_valid;
    logic                     psum_ready;
    logic [BW_PSUM-1:0]       dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [$clog2(COL)-1:0]   dout_idx;
    logic                     dout_last;

    modport slave (
        input  psum_in, psum_valid, dout_ready,
        output psum_ready, dout, dout_valid, dout_idx, dout_last
    );

    modport master (
        output psum_in, psum_valid, dout_ready,
        input  psum_ready, dout, dout_valid, dout_idx, dout_last
    );

endinterface

// File: rtl/psum_drain_fifo.sv
// -----------------------------------------------------------------------------
// psum_fifo
// Synchronous vector FIFO, power-of-two depth, pointers wrap naturally.
//   clk, reset  : clock, asynchronous active-low reset
//   push/push_data : write request (ignored while full)
//   pop/pop_data   : read request (ignored while empty); pop_data shows head
//   full, empty    : decoded from the registered count
//   level          : registered count of stored vectors
// -----------------------------------------------------------------------------
module psum_fifo import npu_drain_pkg::*; #(
    parameter int WIDTH = BW_PSUM_DEF * COL_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == {LVL_W{1'b0}});
    assign level     = count_q;
    assign pop_data  = mem_q[rd_ptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Pointer and occupancy update; push and pop together leave the count as is.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful behind the count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
// Captures whole psum vectors into a small FIFO and serializes each one,
// column 0 first, onto a valid/ready word stream.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   bus        : psum_drain_if.slave (capture stream in, word stream out)
//   fifo_level : vectors queued, not counting the one being serialized
//   overflow   : sticky, set when a strobe arrives while the FIFO is full
// Build option: define PSUM_DRAIN_RELU_EN to clamp negative words to zero as
// they are loaded into the shift register (the FIFO keeps raw psums).
// -----------------------------------------------------------------------------
module psum_drain import npu_drain_pkg::*; #(
    parameter int col     = COL_DEF,
    parameter int bw_psum = BW_PSUM_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    psum_drain_if.slave                bus,
    output logic [$clog2(depth):0]     fifo_level,
    output logic                       overflow
);

    localparam int VEC_W = bw_psum * col;
    localparam int IDX_W = $clog2(col);
    localparam int LVL_W = $clog2(depth) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(col - 1);

    drain_state_e     state_q, state_d;
    logic [VEC_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             overflow_q, overflow_d;

    logic [VEC_W-1:0] fifo_rd_data_s;
    logic [VEC_W-1:0] load_vec_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LVL_W-1:0] fifo_level_s;
    logic             pop_s;
    logic [IDX_W-1:0] idx_nxt_s;

    function automatic logic [bw_psum-1:0] relu_fn(input logic [bw_psum-1:0] w);
`ifdef PSUM_DRAIN_RELU_EN
        return w[bw_psum-1] ? {bw_psum{1'b0}} : w;
`else
        return w;
`endif
    endfunction

    psum_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (depth),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.psum_valid),
        .push_data (bus.psum_in),
        .pop       (pop_s),
        .pop_data  (fifo_rd_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    // No pass-through when full: readiness comes from the registered count only.
    assign bus.psum_ready = ~fifo_full_s;
    assign bus.dout       = shreg_q[bw_psum-1:0];
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_idx   = idx_q;
    assign bus.dout_last  = dout_last_q;
    assign fifo_level     = fifo_level_s;
    assign overflow       = overflow_q;
    assign idx_nxt_s      = idx_q + IDX_W'(1);

    // Head vector as it enters the shift register (optionally ReLU-clamped).
    always_comb begin
        load_vec_s = {VEC_W{1'b0}};
        for (int k = 0; k < col; k++) begin
            load_vec_s[k*bw_psum +: bw_psum] =
                relu_fn(bw_psum'(col_slice(MAX_VEC_W'(fifo_rd_data_s), k, bw_psum)));
        end
    end

    // Sticky drop flag.
    always_comb begin
        overflow_d = overflow_q | (bus.psum_valid & fifo_full_s);
    end

    // Serializer next state: load on idle/non-empty, shift on accept, and chain
    // straight into the next vector after the last column so there is no bubble.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shreg_d      = load_vec_s;
                    idx_d        = {IDX_W{1'b0}};
                    dout_valid_d = 1'b1;
                    dout_last_d  = 1'b0;
                    state_d      = ST_SEND;
                end else begin
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (bus.dout_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d       = idx_nxt_s;
                        shreg_d     = shreg_q >> bw_psum;
                        dout_last_d = (idx_nxt_s == LAST_IDX);
                    end else if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        shreg_d     = load_vec_s;
                        idx_d       = {IDX_W{1'b0}};
                        dout_last_d = 1'b0;
                    end else begin
                        idx_d        = {IDX_W{1'b0}};
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                idx_d        = {IDX_W{1'b0}};
                dout_valid_d = 1'b0;
                dout_last_d  = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // Serializer and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= {VEC_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_drain
// Directed bench for psum_drain (col=8, bw_psum=20, depth=4). Inputs change
// and outputs are sampled 1 time unit after each rising edge. Honours
// PSUM_DRAIN_RELU_EN for the negative-word expectation.
// -----------------------------------------------------------------------------
module tb_psum_drain;

    localparam int COL = 8;
    localparam int BW  = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    logic [COL*BW-1:0] vec;
    logic [63:0]       exp_w;

    psum_drain_if #(.COL(COL), .BW_PSUM(BW)) bus ();

    psum_drain #(.col(COL), .bw_psum(BW), .depth(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_total++;
        assert (got === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        bus.psum_in    = '0;
        bus.psum_valid = 1'b0;
        bus.dout_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_psum_ready", 64'(bus.psum_ready), 64'd1);
        chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("rst_dout",       64'(bus.dout),       64'd0);
        chk("rst_idx",        64'(bus.dout_idx),   64'd0);
        chk("rst_last",       64'(bus.dout_last),  64'd0);
        chk("rst_level",      64'(fifo_level),     64'd0);
        chk("rst_overflow",   64'(overflow),       64'd0);
        reset = 1'b1;
        cyc();

        // Single vector, column k = k+1, consumer always ready.
        for (int k = 0; k < COL; k++) vec[k*BW +: BW] = 20'(k + 1);
        bus.psum_in    = vec;
        bus.psum_valid = 1'b1;
        bus.dout_ready = 1'b1;
        cyc();
        bus.psum_valid = 1'b0;
        chk("t1_level_after_push", 64'(fifo_level),     64'd1);
        chk("t1_valid_after_push", 64'(bus.dout_valid), 64'd0);
        for (int k = 0; k < COL; k++) begin
            cyc();
            chk("t1_valid", 64'(bus.dout_valid), 64'd1);
            chk("t1_dout",  64'(bus.dout),       64'(k + 1));
            chk("t1_idx",   64'(bus.dout_idx),   64'(k));
            chk("t1_last",  64'(bus.dout_last),  (k == COL - 1) ? 64'd1 : 64'd0);
        end
        cyc();
        chk("t1_idle_valid", 64'(bus.dout_valid), 64'd0);
        chk("t1_idle_level", 64'(fifo_level),     64'd0);

        // Five back-to-back pushes with the consumer stalled: vector i has
        // column k = (i+1)*16 + k. The first loads, the other four fill the FIFO.
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < COL; k++) vec[k*BW +: BW] = 20'((i + 1) * 16 + k);
            bus.psum_in    = vec;
            bus.psum_valid = 1'b1;
            cyc();
        end
        bus.psum_valid = 1'b0;
        chk("t2_level_full",  64'(fifo_level),     64'd4);
        chk("t2_ready_low",   64'(bus.psum_ready), 64'd0);
        chk("t2_no_overflow", 64'(overflow),       64'd0);
        chk("t2_dout_valid",  64'(bus.dout_valid), 64'd1);
        chk("t2_dout_head",   64'(bus.dout),       64'd16);
        for (int k = 0; k < COL; k++) vec[k*BW +: BW] = 20'h7_7777;
        bus.psum_in    = vec;
        bus.psum_valid = 1'b1;
        cyc();
        bus.psum_valid = 1'b0;
        chk("t2_overflow_set",   64'(overflow),     64'd1);
        chk("t2_level_unchanged", 64'(fifo_level),  64'd4);
        chk("t2_idx_held",       64'(bus.dout_idx), 64'd0);

        // Advance to column 3, then stall for three cycles.
        bus.dout_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.dout_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cyc();
            chk("t3_stall_dout",  64'(bus.dout),       64'd19);
            chk("t3_stall_idx",   64'(bus.dout_idx),   64'd3);
            chk("t3_stall_valid", 64'(bus.dout_valid), 64'd1);
        end
        chk("t3_overflow_sticky", 64'(overflow), 64'd1);

        // Resume: rest of vector 0, all of vector 1, vector 2 up to column 4,
        // with no gap across vector boundaries.
        bus.dout_ready = 1'b1;
        for (int n = 4; n <= 20; n++) begin
            cyc();
            chk("t4_valid", 64'(bus.dout_valid), 64'd1);
            chk("t4_dout",  64'(bus.dout),       64'((n / 8 + 1) * 16 + n % 8));
            chk("t4_idx",   64'(bus.dout_idx),   64'(n % 8));
            chk("t4_last",  64'(bus.dout_last),  (n % 8 == 7) ? 64'd1 : 64'd0);
        end
        chk("t4_level_two", 64'(fifo_level), 64'd2);

        // Asynchronous reset mid-vector with two vectors queued.
        reset = 1'b0;
        #1;
        chk("t5_rst_valid",    64'(bus.dout_valid), 64'd0);
        chk("t5_rst_dout",     64'(bus.dout),       64'd0);
        chk("t5_rst_idx",      64'(bus.dout_idx),   64'd0);
        chk("t5_rst_last",     64'(bus.dout_last),  64'd0);
        chk("t5_rst_level",    64'(fifo_level),     64'd0);
        chk("t5_rst_overflow", 64'(overflow),       64'd0);
        chk("t5_rst_ready",    64'(bus.psum_ready), 64'd1);
        cyc();
        reset = 1'b1;

        // Fresh vector: column 0 = -5, column k = 0x100+k.
        vec[0 +: BW] = 20'hF_FFFB;
        for (int k = 1; k < COL; k++) vec[k*BW +: BW] = 20'(12'h100 + k);
        bus.psum_in    = vec;
        bus.psum_valid = 1'b1;
        cyc();
        bus.psum_valid = 1'b0;
`ifdef PSUM_DRAIN_RELU_EN
        exp_w = 64'h0;
`else
        exp_w = 64'hF_FFFB;
`endif
        for (int k = 0; k < COL; k++) begin
            cyc();
            chk("t6_valid", 64'(bus.dout_valid), 64'd1);
            chk("t6_idx",   64'(bus.dout_idx),   64'(k));
            chk("t6_dout",  64'(bus.dout),       (k == 0) ? exp_w : 64'(12'h100 + k));
        end
        cyc();
        chk("t6_no_old_data", 64'(bus.dout_valid), 64'd0);
        chk("t6_level_empty", 64'(fifo_level),     64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
